// File: rtl/dual_port_ram_be.sv
// Byte-enable simple dual-port RAM with a post-reset zero-fill FSM; read data appears RD_LATENCY edges after read_en is sampled.
// No backpressure: one write and one read are accepted every cycle once init_done is high; both are ignored while clearing.
module dual_port_ram_be #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]               din,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    byte_en,
    input  logic                                write_en,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    input  logic                                read_en,
    output logic [DATA_WIDTH-1:0]               dout,
    output logic                                dout_valid,
    output logic                                init_done
);
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     clr_cnt_q, clr_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    clearing, wr_fire, rd_fire;
    logic [NUM_LANES-1:0]    mem_be;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic [DATA_WIDTH-1:0]   rd_dat;
    logic [DATA_WIDTH-1:0]   rd_merged;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clearing  = 1'b0;
        if (state_q == CLEAR) begin
            if (CLEAR_ON_RESET == 0) begin
                state_d = READY;
            end else if (clr_cnt_q[ADDR_WIDTH]) begin
                state_d = READY;
            end else begin
                clearing  = 1'b1;
                clr_cnt_d = clr_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
        end
        init_done_d = (state_d == READY);
        wr_fire     = (state_q == READY) && write_en;
        rd_fire     = (state_q == READY) && read_en;
        rd_vld_d    = rd_fire;
    end

    // Clear and user writes share the array's single write port.
    always_comb begin
        mem_wa = clearing ? clr_cnt_q[ADDR_WIDTH-1:0] : waddr;
        mem_wd = clearing ? '0 : din;
        mem_be = '0;
        if (clearing) begin
            mem_be = '1;
        end else if (wr_fire) begin
            mem_be = byte_en;
        end
        if (reset) begin
            mem_be = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    assign init_done = init_done_q;

    // One narrow array per lane keeps each a plain one-write/one-read RAM.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [BYTE_WIDTH-1:0] lane_mem [DEPTH];
        logic [BYTE_WIDTH-1:0] lane_rd_q;

        always_ff @(posedge clk) begin
            if (mem_be[g]) begin
                lane_mem[mem_wa] <= mem_wd[g*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lane_rd_q <= '0;
            end else if (rd_fire) begin
                lane_rd_q <= lane_mem[raddr];
            end
        end

        assign rd_dat[g*BYTE_WIDTH +: BYTE_WIDTH] = lane_rd_q;
    end

    if (RDW_MODE == 1) begin : g_byp
        logic [NUM_LANES-1:0]  byp_be_q, byp_be_d;
        logic [DATA_WIDTH-1:0] byp_dat_q, byp_dat_d;

        always_comb begin
            byp_be_d  = byp_be_q;
            byp_dat_d = byp_dat_q;
            if (rd_fire) begin
                byp_be_d  = (wr_fire && (waddr == raddr)) ? byte_en : '0;
                byp_dat_d = din;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                byp_be_q  <= '0;
                byp_dat_q <= '0;
            end else begin
                byp_be_q  <= byp_be_d;
                byp_dat_q <= byp_dat_d;
            end
        end

        // The array returns pre-write data; colliding lanes are patched from the captured din.
        always_comb begin
            rd_merged = rd_dat;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byp_be_q[i]) begin
                    rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_dat_q[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end else begin : g_nobyp
        assign rd_merged = rd_dat;
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dout_vld_q, dout_vld_d;

        always_comb begin
            dout_vld_d = rd_vld_q;
            dout_d     = rd_vld_q ? rd_merged : dout_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q     <= '0;
                dout_vld_q <= 1'b0;
            end else begin
                dout_q     <= dout_d;
                dout_vld_q <= dout_vld_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_vld_q;
    end else begin : g_lat1
        assign dout       = rd_merged;
        assign dout_valid = rd_vld_q;
    end
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: u_d0 (latency 1, old-data RDW), u_d1 (latency 2, merged RDW), u_d2 (no clear) share one stimulus.
module tb_dual_port_ram_be;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] din;
    logic [NL-1:0] byte_en;
    logic          write_en, read_en;
    logic [DW-1:0] dout0, dout1, dout2;
    logic          vld0, vld1, vld2;
    logic          done0, done1, done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(1),
                       .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_d0 (
        .clk(clk), .reset(reset), .waddr(waddr), .din(din), .byte_en(byte_en),
        .write_en(write_en), .raddr(raddr), .read_en(read_en),
        .dout(dout0), .dout_valid(vld0), .init_done(done0));

    dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(2),
                       .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_d1 (
        .clk(clk), .reset(reset), .waddr(waddr), .din(din), .byte_en(byte_en),
        .write_en(write_en), .raddr(raddr), .read_en(read_en),
        .dout(dout1), .dout_valid(vld1), .init_done(done1));

    dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(1),
                       .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_d2 (
        .clk(clk), .reset(reset), .waddr(waddr), .din(din), .byte_en(byte_en),
        .write_en(write_en), .raddr(raddr), .read_en(read_en),
        .dout(dout2), .dout_valid(vld2), .init_done(done2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
        write_en = 1'b1;
        waddr    = a;
        din      = d;
        byte_en  = be;
        tick();
        write_en = 1'b0;
        byte_en  = '0;
    endtask

    task automatic wait_init(output int cyc, output int seen);
        cyc  = 0;
        seen = 0;
        while (!done0 && cyc < 200) begin
            tick();
            cyc++;
            if (vld0 || vld1) seen++;
        end
    endtask

    initial begin
        int cyc;
        int seen;
        int bad;
        logic [AW-1:0] probe [3];
        probe[0] = 5'd3;
        probe[1] = 5'd7;
        probe[2] = 5'd8;

        reset = 1'b1; write_en = 1'b0; read_en = 1'b0;
        waddr = '0; raddr = '0; din = '0; byte_en = '0;
        @(negedge clk);
        repeat (3) tick();
        check("rst_dout0", dout0, 32'h0);
        check("rst_vld0", 32'(vld0), 32'h0);
        check("rst_done0", 32'(done0), 32'h0);
        check("rst_dout1", dout1, 32'h0);
        check("rst_vld1", 32'(vld1), 32'h0);
        check("rst_done2", 32'(done2), 32'h0);

        // Accesses presented throughout the clear must be ignored.
        reset = 1'b0;
        write_en = 1'b1; waddr = 5'd5; din = 32'hFFFF_FFFF; byte_en = 4'hF;
        read_en = 1'b1; raddr = 5'd5;
        tick();
        check("noclr_done2", 32'(done2), 32'h1);
        check("clr_done0_early", 32'(done0), 32'h0);
        wait_init(cyc, seen);
        cyc = cyc + 1;
        if (vld0 || vld1) seen++;
        write_en = 1'b0; read_en = 1'b0; byte_en = '0;
        check("init_cycles", 32'(cyc), 32'd33);
        check("clr_no_vld", 32'(seen), 32'h0);
        check("clr_done1", 32'(done1), 32'h1);

        bad = 0;
        for (int a = 0; a < 32; a++) begin
            read_en = 1'b1;
            raddr   = AW'(a);
            tick();
            if (!vld0 || dout0 != 32'h0) bad++;
            if (a > 0 && (!vld1 || dout1 != 32'h0)) bad++;
        end
        read_en = 1'b0;
        tick();
        if (!vld1 || dout1 != 32'h0 || vld0) bad++;
        check("clr_readback", 32'(bad), 32'h0);
        tick();

        wr(5'd3, 32'hDEAD_BEEF, 4'b1111);
        wr(5'd3, 32'h1122_3344, 4'b0101);
        read_en = 1'b1; raddr = 5'd3;
        tick();
        read_en = 1'b0;
        check("be_merge0", dout0, 32'hDE22_BE44);
        check("be_vld0", 32'(vld0), 32'h1);
        tick();
        check("be_merge1", dout1, 32'hDE22_BE44);
        check("be_hold0", dout0, 32'hDE22_BE44);
        check("be_vld0_off", 32'(vld0), 32'h0);

        wr(5'd1, 32'h0101_0101, 4'hF);
        wr(5'd2, 32'h0202_0202, 4'hF);
        read_en = 1'b1; raddr = 5'd1;
        tick();
        check("l2_c1_vld", 32'(vld1), 32'h0);
        raddr = 5'd2;
        tick();
        check("l2_c2_vld", 32'(vld1), 32'h1);
        check("l2_c2_dat", dout1, 32'h0101_0101);
        raddr = 5'd3;
        tick();
        read_en = 1'b0;
        check("l2_c3_vld", 32'(vld1), 32'h1);
        check("l2_c3_dat", dout1, 32'h0202_0202);
        tick();
        check("l2_c4_vld", 32'(vld1), 32'h1);
        check("l2_c4_dat", dout1, 32'hDE22_BE44);
        tick();
        check("l2_c5_vld", 32'(vld1), 32'h0);
        check("l2_c5_hold", dout1, 32'hDE22_BE44);

        wr(5'd7, 32'hAAAA_AAAA, 4'hF);
        write_en = 1'b1; waddr = 5'd7; din = 32'h5555_5555; byte_en = 4'b0011;
        read_en = 1'b1; raddr = 5'd7;
        tick();
        write_en = 1'b0; read_en = 1'b0; byte_en = '0;
        check("rdw_old", dout0, 32'hAAAA_AAAA);
        tick();
        check("rdw_new", dout1, 32'hAAAA_5555);

        write_en = 1'b1; waddr = 5'd8; din = 32'h1234_5678; byte_en = 4'hF;
        read_en = 1'b1; raddr = 5'd7;
        tick();
        din = 32'hFFFF_FFFF; byte_en = 4'h0; read_en = 1'b0;
        check("diff_addr0", dout0, 32'hAAAA_5555);
        tick();
        write_en = 1'b0;
        check("diff_addr1", dout1, 32'hAAAA_5555);
        read_en = 1'b1; raddr = 5'd8;
        tick();
        read_en = 1'b0;
        check("be_zero0", dout0, 32'h1234_5678);
        tick();
        check("be_zero1", dout1, 32'h1234_5678);

        // Reset lands with a read still in the latency-2 pipeline.
        read_en = 1'b1; raddr = 5'd8;
        tick();
        read_en = 1'b0;
        reset = 1'b1;
        #1;
        check("midrd_vld1", 32'(vld1), 32'h0);
        check("midrd_dout0", dout0, 32'h0);
        check("midrd_done0", 32'(done0), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_init(cyc, seen);
        check("reclr_cycles", 32'(cyc), 32'd33);
        check("reclr_no_vld", 32'(seen), 32'h0);

        wr(5'd9, 32'h9999_9999, 4'hF);
        read_en = 1'b1; raddr = 5'd9;
        tick();
        check("post_wr9", dout0, 32'h9999_9999);
        for (int i = 0; i < 3; i++) begin
            raddr = probe[i];
            tick();
            check($sformatf("reclr_rd%0d", i), dout0, 32'h0);
            check($sformatf("reclr_vld%0d", i), 32'(vld0), 32'h1);
        end
        read_en = 1'b0;
        tick();
        check("reclr_rd_l2", dout1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_be.md
DUAL_PORT_RAM_BE -- requirements
Module: dual_port_ram_be

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, address width; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of BYTE_WIDTH.
REQ-003 Parameter BYTE_WIDTH, default 8, lane width; NUM_LANES = DATA_WIDTH / BYTE_WIDTH.
REQ-004 Parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 Parameter RDW_MODE, default 0, same-address read-during-write result; 0 = old data, 1 = new (merged) data.
REQ-006 Parameter CLEAR_ON_RESET, default 1; 1 = zero the whole array after reset, 0 = no clear.
REQ-007 clk  input  1  sole clock; all logic is on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 waddr  input  ADDR_WIDTH  write address.
REQ-010 din  input  DATA_WIDTH  write data.
REQ-011 byte_en  input  NUM_LANES  per-lane write enable; bit i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-012 write_en  input  1  write strobe.
REQ-013 raddr  input  ADDR_WIDTH  read address.
REQ-014 read_en  input  1  read strobe.
REQ-015 dout  output  DATA_WIDTH  registered read data.
REQ-016 dout_valid  output  1  one-cycle pulse marking new dout.
REQ-017 init_done  output  1  high once the array is usable.

Function
REQ-018 The FSM SHALL have two states, CLEAR and READY. Reset forces CLEAR with the clear counter at 0.
REQ-019 In CLEAR with CLEAR_ON_RESET=1, one word per cycle SHALL be written to all-zero, at addresses 0 through 2**ADDR_WIDTH-1 in order. After writing the last address the FSM SHALL enter READY on the next edge.
REQ-020 With CLEAR_ON_RESET=0, CLEAR SHALL last exactly one cycle after reset release, with no array writes.
REQ-021 init_done SHALL be 0 in CLEAR and 1 in READY. In READY it SHALL be registered and glitch-free.
REQ-022 In CLEAR, write_en and read_en SHALL be ignored: no user write, no dout_valid, and dout unchanged.
REQ-023 In READY, a write SHALL occur when write_en=1. Only lanes with byte_en[i]=1 at waddr are updated. write_en=1 with byte_en=0 SHALL leave the array unchanged.
REQ-024 read_en=1 at edge N SHALL present mem[raddr] on dout at edge N+RD_LATENCY, with dout_valid=1 for exactly that cycle.
REQ-025 Reads SHALL be fully pipelined: back-to-back read_en yields back-to-back dout_valid.
REQ-026 dout SHALL hold its last value while dout_valid=0.
REQ-027 On a same-cycle write and read with raddr==waddr:
- RDW_MODE=0: the returned word SHALL be the pre-write contents.
- RDW_MODE=1: enabled lanes SHALL come from din and disabled lanes from memory.
REQ-028 A write and a read at different addresses in the same cycle SHALL not interact.
REQ-029 With RD_LATENCY=2, a write at edge N+1 to an address read at edge N SHALL NOT alter that read's result.
REQ-030 The array SHALL be inferable as block RAM: one write port, one read port, plus output and optional pipeline registers. The RDW_MODE=1 bypass SHALL sit outside the array.
REQ-031 Reads SHALL have no reset dependency on array contents. With CLEAR_ON_RESET=0 the contents after power-up are undefined, and the array is not modified by reset.

Reset
REQ-032 While reset=1:
- dout = 0, dout_valid = 0, init_done = 0
- clear counter = 0, FSM = CLEAR
- read pipeline valid bits = 0
REQ-033 Reset asserted mid-clear or mid-read SHALL discard in-flight reads, with no dout_valid after release. Clear SHALL restart from address 0.
REQ-034 Array contents SHALL not be modified asynchronously by reset. With CLEAR_ON_RESET=1 they SHALL be re-cleared by the FSM.

Verification
REQ-035 ADDR_WIDTH=5, CLEAR_ON_RESET=1: release reset -> init_done rises exactly 33 cycles later; reads of all 32 addresses return 0.
REQ-036 Write 0xDEADBEEF to addr 3 with byte_en=1111, then write 0x11223344 with byte_en=0101 -> read addr 3 returns 0xDE22BE44.
REQ-037 RD_LATENCY=2: read_en on three consecutive cycles for addrs 1, 2, 3 -> dout_valid high on cycles N+2, N+3, N+4 with the matching data, and dout held afterwards.
REQ-038 Addr 7 holds 0xAAAAAAAA; same cycle write 0x55555555 with byte_en=0011 and read addr 7 -> RDW_MODE=0 returns 0xAAAAAAAA; RDW_MODE=1 returns 0xAAAA5555.
REQ-039 Assert reset at clear count 10, release -> init_done stays 0 for a further 33 cycles. Addresses written before the reset read 0.
REQ-040 Issue write_en/read_en during CLEAR -> no dout_valid pulse and no effect on contents after init_done.
